// File: rtl/count_sequencer.sv
// count_sequencer
// Run/stop/single-step controller for a small board-level up counter.
// A prescaler turns the fast board clock into one-cycle En pulses while
// running. Debounced button levels are edge-detected here. A wrap tally is
// kept from the counter's carry-out, and the controller stops in DONE once
// the tally reaches MAX_WRAPS.
//
// Build option:
//   COUNT_SEQ_AUTO_RELOAD_EN - when defined, reaching MAX_WRAPS does not
//   enter DONE. The counter gets a one-cycle reset, the tally clears, and the
//   controller keeps running. Done is then tied low.
module count_sequencer #(
    parameter int unsigned PRESCALE  = 100000000, // board clocks per En pulse (2..2^27-1)
    parameter int unsigned WIDTH     = 3,         // counter width, Count is status only
    parameter int unsigned MAX_WRAPS = 4          // wrap count that ends a run (1..255)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Step,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Count,
    input  logic             Carry2,
    output logic             En,
    output logic             CntRst,
    output logic [1:0]       State,
    output logic [7:0]       Wraps,
    output logic             Done
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Prescaler width; PRESCALE-1 always fits in $clog2(PRESCALE) bits.
    localparam int unsigned   PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [7:0]    WRAP_LIMIT = 8'(MAX_WRAPS);
    localparam logic [7:0]    WRAP_SAT   = 8'hFF;

    // Button history bit positions.
    localparam int B_STEP  = 0;
    localparam int B_START = 1;
    localparam int B_STOP  = 2;
    localparam int B_CLEAR = 3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]    btn_prev_q;
    state_t        state_q,  state_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic          en_q,     en_d;
    logic          cntrst_q, cntrst_d;
    logic [7:0]    wraps_q,  wraps_d;

    // ------------------------------------------------------------------
    // Button edge detection
    // ------------------------------------------------------------------
    logic clear_edge;
    logic stop_edge;
    logic start_edge;
    logic step_edge;

    // Remember last cycle's button levels. Clearing them in reset means a
    // button held through reset is seen as a fresh press right afterwards.
    // NOTE: clocked state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            btn_prev_q <= '0;
        end else begin
            btn_prev_q <= {Clear, Stop, Start, Step};
        end
    end

    assign clear_edge = Clear & ~btn_prev_q[B_CLEAR];
    assign stop_edge  = Stop  & ~btn_prev_q[B_STOP];
    assign start_edge = Start & ~btn_prev_q[B_START];
    assign step_edge  = Step  & ~btn_prev_q[B_STEP];

    // ------------------------------------------------------------------
    // Prescaler terminal and wrap tally helpers
    // ------------------------------------------------------------------
    logic       presc_last;
    logic       wrap_hit;
    logic [7:0] wraps_inc;
    logic       limit_hit;

    assign presc_last = (presc_q == PRESC_LAST);

    // A wrap is a cycle where we are driving En and the counter reports carry.
    assign wrap_hit  = en_q & Carry2;
    assign wraps_inc = (wraps_q == WRAP_SAT) ? WRAP_SAT : wraps_q + 8'd1;
    assign limit_hit = wrap_hit && (wraps_inc == WRAP_LIMIT);

    // Count is only a status input; fold it into a sink so it is consumed.
    logic count_status_unused;
    assign count_status_unused = ^Count;

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    // Decide the next state, prescaler, tally and the En/CntRst pulses.
    // Override order: per-state behaviour, then the wrap limit, then Clear.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_d  = state_q;
        presc_d  = presc_q;
        en_d     = 1'b0;
        cntrst_d = 1'b0;
        wraps_d  = wrap_hit ? wraps_inc : wraps_q;

        unique case (state_q)
            S_IDLE: begin
                // Stop has nothing to stop here.
                presc_d = '0;
                if (start_edge) begin
                    state_d = S_RUN;
                end else if (step_edge) begin
                    // The STEP state is entered together with its single En.
                    state_d = S_STEP;
                    en_d    = 1'b1;
                end
            end

            S_RUN: begin
                // Start and Step are ignored while running.
                if (stop_edge) begin
                    // Stop beats a coinciding terminal count: no En issued.
                    state_d = S_IDLE;
                    presc_d = '0;
                end else if (presc_last) begin
                    presc_d = '0;
                    en_d    = 1'b1;
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end

            S_STEP: begin
                // The En pulse is already on the wire; Stop cannot recall it.
                state_d = S_IDLE;
                presc_d = '0;
            end

            S_DONE: begin
                // Only Start leaves DONE; it restarts from a reset counter.
                presc_d = '0;
                if (start_edge) begin
                    state_d  = S_RUN;
                    cntrst_d = 1'b1;
                    wraps_d  = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                presc_d = '0;
            end
        endcase

`ifdef COUNT_SEQ_AUTO_RELOAD_EN
        // Reload: reset the counter, restart the tally, keep the current
        // flow (RUN keeps its prescaler phase, STEP still returns to IDLE).
        if (limit_hit) begin
            cntrst_d = 1'b1;
            wraps_d  = '0;
        end
`else
        // Reaching the limit parks the controller in DONE from any state.
        if (limit_hit) begin
            state_d = S_DONE;
            presc_d = '0;
            en_d    = 1'b0;
        end
`endif

        // Clear wins over everything else, in every state.
        if (clear_edge) begin
            state_d  = S_IDLE;
            presc_d  = '0;
            en_d     = 1'b0;
            cntrst_d = 1'b1;
            wraps_d  = '0;
        end

        // The counter must never see reset and enable together.
        if (cntrst_d) begin
            en_d = 1'b0;
        end
    end

    // Register controller state and the outputs to the counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            en_q     <= 1'b0;
            cntrst_q <= 1'b0;
            wraps_q  <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            en_q     <= en_d;
            cntrst_q <= cntrst_d;
            wraps_q  <= wraps_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign En     = en_q;
    assign CntRst = cntrst_q;
    assign State  = state_q;
    assign Wraps  = wraps_q;

`ifdef COUNT_SEQ_AUTO_RELOAD_EN
    assign Done = 1'b0;
`else
    assign Done = (state_q == S_DONE);
`endif

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    // Reset and enable to the counter are mutually exclusive.
    a_no_en_with_rst : assert property (@(posedge Clk) disable iff (Rst)
        !(en_q && cntrst_q));

    // STEP lasts exactly one cycle.
    a_step_one_cycle : assert property (@(posedge Clk) disable iff (Rst)
        (state_q == S_STEP) |=> (state_q != S_STEP));

    // No enable is issued while parked in DONE.
    a_done_quiet : assert property (@(posedge Clk) disable iff (Rst)
        (state_q == S_DONE) |-> !en_q);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a 3-bit counter beside it.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_count_sequencer;

    localparam int PRESCALE  = 4;
    localparam int WIDTH     = 3;
    localparam int MAX_WRAPS = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             step;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             carry2;
    logic             en;
    logic             cntrst;
    logic [1:0]       state;
    logic [7:0]       wraps;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_sequencer #(
        .PRESCALE (PRESCALE),
        .WIDTH    (WIDTH),
        .MAX_WRAPS(MAX_WRAPS)
    ) dut (
        .Clk   (clk),
        .Rst   (rst),
        .Start (start),
        .Stop  (stop),
        .Step  (step),
        .Clear (clear),
        .Count (count),
        .Carry2(carry2),
        .En    (en),
        .CntRst(cntrst),
        .State (state),
        .Wraps (wraps),
        .Done  (done)
    );

    // The board counter the controller drives.
    always_ff @(posedge clk) begin
        if (rst || cntrst) count <= '0;
        else if (en)       count <= count + 3'd1;
    end
    assign carry2 = en & (count == 3'b111);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; step = 1'b0; clear = 1'b0;
        tick(); tick();
        n_checks++; if (en !== 1'b0)      begin n_fail++; $display("FAIL reset_en: got %b expected 0", en); end
        n_checks++; if (cntrst !== 1'b0)  begin n_fail++; $display("FAIL reset_cntrst: got %b expected 0", cntrst); end
        n_checks++; if (state !== 2'b00)  begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
        n_checks++; if (wraps !== 8'd0)   begin n_fail++; $display("FAIL reset_wraps: got %0d expected 0", wraps); end
        n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
        tick();
        n_checks++; if (state !== 2'b01)  begin n_fail++; $display("FAIL held_start_edge: state got %b expected 01", state); end
        start = 1'b0; clear = 1'b1;
        tick();
        n_checks++; if (state !== 2'b00)  begin n_fail++; $display("FAIL reset_clear_state: got %b expected 00", state); end
        n_checks++; if (cntrst !== 1'b1)  begin n_fail++; $display("FAIL reset_clear_cntrst: got %b expected 1", cntrst); end
        clear = 1'b0;
        tick();
        n_checks++; if (cntrst !== 1'b0)  begin n_fail++; $display("FAIL reset_clear_cntrst_end: got %b expected 0", cntrst); end
        n_checks++; if (count !== 3'd0)   begin n_fail++; $display("FAIL reset_clear_count: got %0d expected 0", count); end
    endtask

    // Start, then 8 En pulses every 4 cycles with the first 4 cycles after RUN entry.
    task automatic test_run();
        start = 1'b1;
        tick();
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL run_entry: state got %b expected 01", state); end
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            n_checks++;
            if (en !== 1'((k % 4) == 0)) begin
                n_fail++; $display("FAIL run_en_k%0d: got %b expected %b", k, en, 1'((k % 4) == 0));
            end
        end
        n_checks++; if (carry2 !== 1'b1) begin n_fail++; $display("FAIL run_carry: got %b expected 1", carry2); end
        tick();
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL run_count: got %0d expected 0", count); end
        n_checks++; if (wraps !== 8'd1)  begin n_fail++; $display("FAIL run_wraps: got %0d expected 1", wraps); end
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL run_state: got %b expected 01", state); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL run_done: got %b expected 0", done); end
    endtask

    // Continues from test_run: prescaler is 1 now, terminal two cycles later.
    task automatic test_stop_terminal();
        tick(); tick();
        stop = 1'b1;
        tick();
        n_checks++; if (en !== 1'b0)     begin n_fail++; $display("FAIL stop_term_en: got %b expected 0", en); end
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL stop_term_state: got %b expected 00", state); end
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL stop_term_count: got %0d expected 0", count); end
        stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL stop_idle_en_%0d: got %b expected 0", i, en); end
        end
    endtask

    task automatic test_step();
        stop = 1'b1; tick(); stop = 1'b0; tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL idle_stop_state: got %b expected 00", state); end
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            n_checks++; if (en !== 1'b1)     begin n_fail++; $display("FAIL step%0d_en: got %b expected 1", i, en); end
            n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL step%0d_state: got %b expected 10", i, state); end
            step = 1'b0;
            tick();
            n_checks++; if (en !== 1'b0)     begin n_fail++; $display("FAIL step%0d_en_end: got %b expected 0", i, en); end
            n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL step%0d_idle: got %b expected 00", i, state); end
            tick();
            n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL step%0d_count: got %0d expected %0d", i, count, i + 1); end
        end
    endtask

    task automatic test_done();
        clear = 1'b1;
        tick();
        n_checks++; if (cntrst !== 1'b1) begin n_fail++; $display("FAIL done_pre_clear: cntrst got %b expected 1", cntrst); end
        clear = 1'b0;
        tick();
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL done_pre_count: got %0d expected 0", count); end
        n_checks++; if (wraps !== 8'd0)  begin n_fail++; $display("FAIL done_pre_wraps: got %0d expected 0", wraps); end
        start = 1'b1;
        tick();
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL done_run_entry: got %b expected 01", state); end
        start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            n_checks++;
            if (en !== 1'((k % 4) == 0)) begin
                n_fail++; $display("FAIL done_run_en_k%0d: got %b expected %b", k, en, 1'((k % 4) == 0));
            end
        end
        tick();
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL reload_state: got %b expected 01", state); end
        n_checks++; if (cntrst !== 1'b1) begin n_fail++; $display("FAIL reload_cntrst: got %b expected 1", cntrst); end
        n_checks++; if (wraps !== 8'd0)  begin n_fail++; $display("FAIL reload_wraps: got %0d expected 0", wraps); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reload_done: got %b expected 0", done); end
        tick();
        n_checks++; if (cntrst !== 1'b0) begin n_fail++; $display("FAIL reload_cntrst_end: got %b expected 0", cntrst); end
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL reload_count: got %0d expected 0", count); end
        tick();
        n_checks++; if (en !== 1'b0)     begin n_fail++; $display("FAIL reload_en_early: got %b expected 0", en); end
        tick();
        n_checks++; if (en !== 1'b1)     begin n_fail++; $display("FAIL reload_en_period: got %b expected 1", en); end
`else
        n_checks++; if (state !== 2'b11) begin n_fail++; $display("FAIL done_state: got %b expected 11", state); end
        n_checks++; if (done !== 1'b1)   begin n_fail++; $display("FAIL done_flag: got %b expected 1", done); end
        n_checks++; if (wraps !== 8'd2)  begin n_fail++; $display("FAIL done_wraps: got %0d expected 2", wraps); end
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL done_count: got %0d expected 0", count); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) step = 1'b1;
            if (i == 9) begin step = 1'b0; stop = 1'b1; end
            if (i == 12) stop = 1'b0;
            tick();
            n_checks++; if (en !== 1'b0)     begin n_fail++; $display("FAIL done_quiet_en_%0d: got %b expected 0", i, en); end
            n_checks++; if (state !== 2'b11) begin n_fail++; $display("FAIL done_hold_%0d: got %b expected 11", i, state); end
        end
        start = 1'b1;
        tick();
        n_checks++; if (cntrst !== 1'b1) begin n_fail++; $display("FAIL restart_cntrst: got %b expected 1", cntrst); end
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL restart_state: got %b expected 01", state); end
        n_checks++; if (wraps !== 8'd0)  begin n_fail++; $display("FAIL restart_wraps: got %0d expected 0", wraps); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL restart_done: got %b expected 0", done); end
        start = 1'b0;
        tick();
        n_checks++; if (cntrst !== 1'b0) begin n_fail++; $display("FAIL restart_cntrst_end: got %b expected 0", cntrst); end
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL restart_count: got %0d expected 0", count); end
`endif
    endtask

    // Run until two En pulses have landed, then Clear and Start together.
    task automatic test_clear_start(input int lead);
        repeat (lead) tick();
        n_checks++; if (count !== 3'd2)  begin n_fail++; $display("FAIL cs_pre_count: got %0d expected 2", count); end
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL cs_pre_state: got %b expected 01", state); end
        clear = 1'b1; start = 1'b1;
        tick();
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL cs_state: got %b expected 00", state); end
        n_checks++; if (cntrst !== 1'b1) begin n_fail++; $display("FAIL cs_cntrst: got %b expected 1", cntrst); end
        n_checks++; if (en !== 1'b0)     begin n_fail++; $display("FAIL cs_en: got %b expected 0", en); end
        clear = 1'b0; start = 1'b0;
        tick();
        n_checks++; if (cntrst !== 1'b0) begin n_fail++; $display("FAIL cs_cntrst_end: got %b expected 0", cntrst); end
        n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL cs_count: got %0d expected 0", count); end
        n_checks++; if (wraps !== 8'd0)  begin n_fail++; $display("FAIL cs_wraps: got %0d expected 0", wraps); end
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL cs_idle: got %b expected 00", state); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (en !== 1'b0)     begin n_fail++; $display("FAIL cs_no_en_%0d: got %b expected 0", i, en); end
            n_checks++; if (cntrst !== 1'b0) begin n_fail++; $display("FAIL cs_one_cntrst_%0d: got %b expected 0", i, cntrst); end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stop_terminal();
        test_step();
        test_done();
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
        test_clear_start(5);
`else
        test_clear_start(8);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Run/stop/single-step controller for the board-level 3-bit up counter. It drives the counter's En input and its reset input, and it keeps a wrap tally from the counter's carry-out. A prescaler turns the fast board clock into one-cycle count enables. Start/Stop/Step/Clear arrive as debounced button levels; edge detection is done here.

Parameters:
PRESCALE, 100000000, board clocks per En pulse in RUN (legal range 2..2^27-1).
WIDTH, 3, counter width; used only for the Count input.
MAX_WRAPS, 4, wrap count that forces DONE (legal range 1..255).

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst  input  1  synchronous reset, active high
Start  input  1  debounced level, acts on rising edge
Stop  input  1  debounced level, acts on rising edge
Step  input  1  debounced level, acts on rising edge
Clear  input  1  debounced level, acts on rising edge
Count  input  WIDTH  current counter value, for status only
Carry2  input  1  counter carry-out; high when En=1 and Count is all ones
En  output  1  registered enable to the counter, one-cycle pulses
CntRst  output  1  registered one-cycle reset pulse to the counter
State  output  2  IDLE=00, RUN=01, STEP=10, DONE=11
Wraps  output  8  number of counter wraps since the last clear
Done  output  1  high while State==DONE

Behaviour:
- Reset: Rst sampled high on a Clk edge clears everything.
  - En=0, CntRst=0, State=IDLE, Wraps=0, Done=0, prescaler=0.
  - Edge-detect history registers reset to 0, so a button held through reset counts as an edge on the first cycle after reset.
  - Rst mid-operation aborts any pending En pulse.
- Edge detect: edge = level & ~prev; prev is registered every cycle.
- Priority when several edges occur in the same cycle: Clear > Stop > Start > Step.
- Clear edge (any state):
  - CntRst=1 on the next cycle, for exactly one cycle.
  - Wraps=0, prescaler=0, State goes to IDLE, En=0.
- IDLE:
  - En=0.
  - Start edge: State goes to RUN next cycle, prescaler cleared.
  - Step edge: State goes to STEP next cycle.
  - Stop edge: no effect.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - When prescaler==PRESCALE-1, En=1 on the following cycle.
  - Start edge n → State=RUN at n+1, first En at n+1+PRESCALE, then one pulse every PRESCALE cycles.
  - Stop edge: State goes to IDLE next cycle and the prescaler is cleared. If the terminal count occurs in the same cycle, Stop wins and no En is issued.
  - Step and Start edges are ignored.
- STEP:
  - State is entered with En=1; it lasts exactly one cycle, then State goes to IDLE.
  - Step edge n → En high at cycle n+1 only.
  - A Stop edge during STEP does not suppress the pulse.
- Wrap tally:
  - On any cycle with En=1 and Carry2=1, Wraps increments (saturates at 255).
  - If the incremented value equals MAX_WRAPS, the next state is DONE, overriding RUN or the return to IDLE.
- DONE:
  - En=0, Done=1, prescaler held at 0.
  - Start edge: CntRst pulses for one cycle, Wraps=0, State goes to RUN.
  - Step and Stop edges are ignored.
- CntRst and En are never high in the same cycle.

Optional Feature:
COUNT_SEQ_AUTO_RELOAD_EN
- Defined: reaching MAX_WRAPS does not enter DONE.
  - The controller issues a one-cycle CntRst pulse, clears Wraps to 0 and stays in RUN; the prescaler keeps running.
  - The next En pulse comes PRESCALE cycles after the previous one.
  - If reload was triggered from STEP, State returns to IDLE.
  - Done is tied to 0.
- Undefined: DONE behaviour as specified above.

Test Plan (PRESCALE=4, WIDTH=3, MAX_WRAPS=2, counter instantiated alongside the controller):
1. Rst high for 2 cycles with Start held high → En=0, CntRst=0, State=00, Wraps=0, Done=0; on the first post-reset cycle Start registers an edge → State=01 next cycle.
2. Start pulse at cycle 10 → En high at cycles 15, 19, 23, …; after 8 En pulses Count=0 and Wraps=1.
3. In RUN, assert Stop so its edge coincides with the prescaler terminal → no En next cycle, State=00, Count unchanged.
4. From IDLE with Count=0, three separate Step pulses → exactly three single-cycle En pulses, Count=3, State returns to 00 each time.
5. Start and run 16 En pulses → Wraps=2, State=11, Done=1, En stays 0 for 20 further cycles; then a Start pulse → CntRst for one cycle, Count=0, Wraps=0, State=01. With COUNT_SEQ_AUTO_RELOAD_EN defined → State stays 01, CntRst pulses once, Wraps=0, Done=0.
6. Clear and Start edges in the same cycle while in RUN → State=00, exactly one CntRst cycle, Count=0, Wraps=0, no En.
